// File: rtl/asg_slew_pkg.sv
// Shared types and defaults for the ASG output slew-rate limiter.
package asg_slew_pkg;

  localparam int DW_DEF = 14;

  typedef enum logic [1:0] {
    ST_PARK     = 2'd0,
    ST_RAMP_IN  = 2'd1,
    ST_RUN      = 2'd2,
    ST_RAMP_OUT = 2'd3
  } slew_state_t;

endpackage

// File: rtl/asg_slew_step.sv
// One limited step from cur toward tgt. The step is at most slew per cycle,
// or a direct jump when slew is zero.
module asg_slew_step
  import asg_slew_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] cur,
  input  logic signed [DW-1:0] tgt,
  input  logic        [DW-1:0] slew,
  output logic signed [DW-1:0] nxt,
  output logic                 lim
);

  logic signed [DW:0] diff;
  logic        [DW:0] mag;

  // One extra bit keeps diff and |diff| exact for any pair of DW-bit samples.
  always_comb begin
    diff = $signed({tgt[DW-1], tgt}) - $signed({cur[DW-1], cur});
    mag  = $unsigned(diff[DW] ? -diff : diff);
    lim  = (slew != '0) && (mag > {1'b0, slew});
    // The output only moves toward tgt by at most |diff|, so the result stays in range.
    if (!lim) begin
      nxt = tgt;
    end else if (diff[DW]) begin
      nxt = cur - $signed(slew);
    end else begin
      nxt = cur + $signed(slew);
    end
  end

endmodule

// File: rtl/red_pitaya_asg_slew.sv
// Soft-start/soft-stop and slew-rate limiter between one ASG channel and the DAC mux.
// The block has input registers, a four-state ramp FSM, a registered output and a saturating clip counter.
module red_pitaya_asg_slew
  import asg_slew_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = 32
) (
  input  logic          dac_clk_i,
  input  logic          dac_rst_i,
  input  logic [DW-1:0] dat_i,
  input  logic          en_i,
  input  logic [DW-1:0] set_slew_i,
  input  logic [DW-1:0] set_park_i,
  input  logic          clr_i,
  output logic [DW-1:0] dat_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    state_o,
  output logic [CW-1:0] clip_cnt_o
);

  logic signed [DW-1:0] dat_r_q, dat_r_d;
  logic signed [DW-1:0] park_r_q, park_r_d;
  logic        [DW-1:0] slew_r_q, slew_r_d;
  logic signed [DW-1:0] dat_o_q, dat_o_d;
  slew_state_t          state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic        [CW-1:0] clip_cnt_q, clip_cnt_d;

  logic signed [DW-1:0] tgt;
  logic signed [DW-1:0] step_nxt;
  logic                 step_lim;

  always_comb begin
    tgt = ((state_q == ST_RAMP_IN) || (state_q == ST_RUN)) ? dat_r_q : park_r_q;
  end

  asg_slew_step #(.DW(DW)) u_step (
    .cur  (dat_o_q),
    .tgt  (tgt),
    .slew (slew_r_q),
    .nxt  (step_nxt),
    .lim  (step_lim)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dat_r_d    = dat_i;
    park_r_d   = set_park_i;
    slew_r_d   = set_slew_i;
    dat_o_d    = step_nxt;
    state_d    = state_q;
    done_d     = 1'b0;
    clip_cnt_d = clip_cnt_q;

    unique case (state_q)
      ST_PARK: begin
        if (en_i) state_d = ST_RAMP_IN;
      end
      ST_RAMP_IN: begin
        if (!en_i) begin
          state_d = ST_RAMP_OUT;
        end else if (!step_lim) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) state_d = ST_RAMP_OUT;
      end
      ST_RAMP_OUT: begin
        if (en_i) begin
          state_d = ST_RAMP_IN;
        end else if (!step_lim) begin
          state_d = ST_PARK;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_PARK;
    endcase

    busy_d = (state_d == ST_RAMP_IN) || (state_d == ST_RAMP_OUT);

    // Clear has priority over a coincident count.
    if (clr_i) begin
      clip_cnt_d = '0;
    end else if ((state_q == ST_RUN) && step_lim && (clip_cnt_q != '1)) begin
      clip_cnt_d = clip_cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      dat_r_q    <= '0;
      park_r_q   <= '0;
      slew_r_q   <= '0;
      dat_o_q    <= '0;
      state_q    <= ST_PARK;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      dat_r_q    <= dat_r_d;
      park_r_q   <= park_r_d;
      slew_r_q   <= slew_r_d;
      dat_o_q    <= dat_o_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign dat_o      = dat_o_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign state_o    = state_q;
  assign clip_cnt_o = clip_cnt_q;

endmodule

// File: tb/tb_red_pitaya_asg_slew.sv
// Directed bench for red_pitaya_asg_slew: table of soft-start/soft-stop cycles plus
// hand sequences for bypass, reversal, clip counting and asynchronous reset.
module tb_red_pitaya_asg_slew;

  localparam int DW = 14;
  localparam int CW = 32;

  localparam logic [1:0] S_PARK = 2'd0;
  localparam logic [1:0] S_IN   = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] dat_i;
  logic                 en_i;
  logic        [DW-1:0] slew_i;
  logic signed [DW-1:0] park_i;
  logic                 clr_i;
  logic signed [DW-1:0] dat_o;
  logic                 busy_o;
  logic                 done_o;
  logic [1:0]           state_o;
  logic [CW-1:0]        clip_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  red_pitaya_asg_slew #(.DW(DW), .CW(CW)) dut (
    .dac_clk_i  (clk),
    .dac_rst_i  (rst),
    .dat_i      (dat_i),
    .en_i       (en_i),
    .set_slew_i (slew_i),
    .set_park_i (park_i),
    .clr_i      (clr_i),
    .dat_o      (dat_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .state_o    (state_o),
    .clip_cnt_o (clip_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    int         dat;
    int         slew;
    int         exp_dat;
    logic [1:0] exp_state;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic en, input int dat, input int slew, input int exp_dat,
                              input logic [1:0] exp_state, input logic exp_busy, input logic exp_done);
    vec_t v;
    v.en = en; v.dat = dat; v.slew = slew; v.exp_dat = exp_dat;
    v.exp_state = exp_state; v.exp_busy = exp_busy; v.exp_done = exp_done;
    return v;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Soft start 0 -> 1000 at slew 100, then soft stop from -8192 at slew 4096.
    tbl[0]  = mk(1'b0,  1000,  100,     0, S_PARK, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1,  1000,  100,     0, S_IN,   1'b1, 1'b0);
    tbl[2]  = mk(1'b1,  1000,  100,   100, S_IN,   1'b1, 1'b0);
    tbl[3]  = mk(1'b1,  1000,  100,   200, S_IN,   1'b1, 1'b0);
    tbl[4]  = mk(1'b1,  1000,  100,   300, S_IN,   1'b1, 1'b0);
    tbl[5]  = mk(1'b1,  1000,  100,   400, S_IN,   1'b1, 1'b0);
    tbl[6]  = mk(1'b1,  1000,  100,   500, S_IN,   1'b1, 1'b0);
    tbl[7]  = mk(1'b1,  1000,  100,   600, S_IN,   1'b1, 1'b0);
    tbl[8]  = mk(1'b1,  1000,  100,   700, S_IN,   1'b1, 1'b0);
    tbl[9]  = mk(1'b1,  1000,  100,   800, S_IN,   1'b1, 1'b0);
    tbl[10] = mk(1'b1,  1000,  100,   900, S_IN,   1'b1, 1'b0);
    tbl[11] = mk(1'b1,  1000,  100,  1000, S_RUN,  1'b0, 1'b1);
    tbl[12] = mk(1'b1,  1000,  100,  1000, S_RUN,  1'b0, 1'b0);
    tbl[13] = mk(1'b1, -8192,    0,  1000, S_RUN,  1'b0, 1'b0);
    tbl[14] = mk(1'b1, -8192,    0, -8192, S_RUN,  1'b0, 1'b0);
    tbl[15] = mk(1'b1, -8192, 4096, -8192, S_RUN,  1'b0, 1'b0);
    tbl[16] = mk(1'b0, -8192, 4096, -8192, S_OUT,  1'b1, 1'b0);
    tbl[17] = mk(1'b0, -8192, 4096, -4096, S_OUT,  1'b1, 1'b0);
    tbl[18] = mk(1'b0, -8192, 4096,     0, S_PARK, 1'b0, 1'b1);
    tbl[19] = mk(1'b0, -8192, 4096,     0, S_PARK, 1'b0, 1'b0);

    rst = 1'b1; en_i = 1'b0; dat_i = 14'sd1000; slew_i = 14'd100; park_i = '0; clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dat", dat_o, 0);
    check("rst_state", state_o, S_PARK);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", clip_cnt_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      en_i   = tbl[i].en;
      dat_i  = DW'(tbl[i].dat);
      slew_i = DW'(tbl[i].slew);
      tick();
      check($sformatf("tbl%0d_dat", i), dat_o, tbl[i].exp_dat);
      check($sformatf("tbl%0d_state", i), state_o, tbl[i].exp_state);
      check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].exp_busy);
      check($sformatf("tbl%0d_done", i), done_o, tbl[i].exp_done);
    end
    check("tbl_cnt", clip_cnt_o, 0);

    // Bypass: PARK -> RAMP_IN -> RUN in one cycle each, then exact tracking.
    begin
      logic signed [DW-1:0] prev_d;
      slew_i = '0; dat_i = 14'sd8191; en_i = 1'b0;
      tick(); tick();
      en_i = 1'b1;
      tick();
      check("byp_in_state", state_o, S_IN);
      check("byp_in_dat", dat_o, 0);
      tick();
      check("byp_run_state", state_o, S_RUN);
      check("byp_run_done", done_o, 1);
      check("byp_run_dat", dat_o, 8191);
      prev_d = 14'sd8191;
      for (int k = 0; k < 12; k++) begin
        dat_i = (k % 2 == 0) ? -14'sd8191 : 14'sd8191;
        tick();
        check($sformatf("byp_trk%0d", k), dat_o, prev_d);
        prev_d = dat_i;
      end
      check("byp_cnt", clip_cnt_o, 0);
      en_i = 1'b0;
      tick();
      check("byp_out_state", state_o, S_OUT);
      check("byp_out_dat", dat_o, prev_d);
      tick();
      check("byp_park_state", state_o, S_PARK);
      check("byp_park_done", done_o, 1);
      check("byp_park_dat", dat_o, 0);
    end

    // Reversal: ramp 0 -> 2000 at 100, drop en_i once 600 is seen.
    begin
      bit found = 1'b0;
      slew_i = 14'd100; dat_i = 14'sd2000; en_i = 1'b0;
      tick();
      en_i = 1'b1;
      for (int c = 0; c < 60 && !found; c++) begin
        tick();
        if (dat_o == 14'sd600) found = 1'b1;
      end
      check("rev_reach600", found, 1);
      en_i = 1'b0;
      for (int j = 0; j < 8; j++) begin
        tick();
        check($sformatf("rev%0d_dat", j), dat_o, 700 - 100 * j);
        check($sformatf("rev%0d_done", j), done_o, (j == 7) ? 1 : 0);
        check($sformatf("rev%0d_state", j), state_o, (j == 7) ? S_PARK : S_OUT);
      end
    end

    // Clip counting: four limited steps 0 -> 50, then clear against a limited step.
    dat_i = '0; slew_i = 14'd10; en_i = 1'b1;
    repeat (3) tick();
    check("clip_run_state", state_o, S_RUN);
    check("clip_cnt0", clip_cnt_o, 0);
    dat_i = 14'sd50;
    repeat (6) tick();
    check("clip_dat50", dat_o, 50);
    check("clip_cnt4", clip_cnt_o, 4);
    dat_i = 14'sd100;
    tick();
    clr_i = 1'b1;
    tick();
    check("clip_clr_dat", dat_o, 60);
    check("clip_clr_cnt", clip_cnt_o, 0);
    clr_i = 1'b0;
    repeat (4) tick();
    check("clip_dat100", dat_o, 100);
    check("clip_cnt3", clip_cnt_o, 3);

    // Asynchronous reset in the middle of a ramp-out.
    en_i = 1'b0;
    repeat (3) tick();
    check("arst_pre_state", state_o, S_OUT);
    check("arst_pre_dat", dat_o, 80);
    #3;
    rst = 1'b1;
    #1;
    check("arst_dat", dat_o, 0);
    check("arst_state", state_o, S_PARK);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_cnt", clip_cnt_o, 0);
    #2;
    rst = 1'b0;
    tick();
    check("arst_post_state", state_o, S_PARK);
    check("arst_post_dat", dat_o, 0);
    check("arst_post_done", done_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
